// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the IF/MEM memory arbiter.
// Holds the FSM state enum, the owner enum and default bus widths.
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter sharing one backing port between the IF fetch
// path and the MEM load/store path; data wins unless MEM_ARB_FAIR_EN is set.
// Ports: clk, rst (async, active-high);
//   fetch side  if_req/if_addr -> if_rdata/if_valid/if_stall;
//   data side   d_req/d_we/d_addr/d_wdata -> d_rdata/d_valid/d_stall;
//   memory side mem_req/mem_we/mem_addr/mem_wdata <- mem_rdata/mem_ready.
// Macro MEM_ARB_FAIR_EN: after STARVE_LIMIT consecutive data grants taken
//   while a fetch waits, the next contested arbitration goes to the fetch.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_stall,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              d_stall,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    state_e            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic              if_valid_q, if_valid_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              d_valid_q, d_valid_d;

    logic              quiet;
    logic              start;
    owner_e            win;

    // No grant in the cycle a valid pulses: the finishing requester still
    // shows its old req there, so arbitration waits one more IDLE cycle.
    assign quiet = (state_q == IDLE) && !if_valid_q && !d_valid_q;
    assign start = quiet && (if_req || d_req);

`ifdef MEM_ARB_FAIR_EN
    localparam int unsigned     CntW  = $clog2(STARVE_LIMIT + 1);
    localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

    logic [CntW-1:0] starve_q, starve_d;
    logic            fetch_due;

    assign fetch_due = if_req && (starve_q >= Limit);
    assign win       = (d_req && !fetch_due) ? OWN_D : OWN_I;

    // Counts data grants taken over a waiting fetch; saturates at Limit.
    always_comb begin
        starve_d = starve_q;
        if (start) begin
            if (win == OWN_I) begin
                starve_d = '0;
            end else if (if_req && (starve_q < Limit)) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign win = d_req ? OWN_D : OWN_I;

    // STARVE_LIMIT only matters when fairness is built in.
    if (STARVE_LIMIT == 0) begin : g_no_fairness
    end
`endif

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_valid_d  = 1'b0;
        d_valid_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mem_req_d = 1'b1;
                    if (win == OWN_D) begin
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        state_d     = BUSY_D;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        state_d     = BUSY_I;
                    end
                end
            end
            BUSY_I: begin
                if (mem_ready) begin
                    if_rdata_d = mem_rdata;
                    if_valid_d = 1'b1;
                    mem_req_d  = 1'b0;
                    state_d    = IDLE;
                end
            end
            BUSY_D: begin
                if (mem_ready) begin
                    // Stores keep the last load data visible.
                    if (!mem_we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                    d_valid_d = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                mem_req_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            if_valid_q  <= 1'b0;
            d_rdata_q   <= '0;
            d_valid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            if_valid_q  <= if_valid_d;
            d_rdata_q   <= d_rdata_d;
            d_valid_q   <= d_valid_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign if_valid  = if_valid_q;
    assign d_rdata   = d_rdata_q;
    assign d_valid   = d_valid_q;
    assign if_stall  = if_req && !if_valid_q;
    assign d_stall   = d_req && !d_valid_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter for the 5-stage pipelined core. It shares one backing memory port between the IF-stage instruction fetch and the MEM-stage load/store path. It sequences each access as a request/ready transaction and returns data with a one-cycle completion pulse. Until a requester's access completes, its stall output holds the pipeline.

## Interface
Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, consecutive data grants allowed while a fetch waits (used only with MEM_ARB_FAIR_EN).

Ports:
- clk  in  1  core clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- if_req  in  1  fetch request, level, held until if_valid.
- if_addr  in  ADDR_W  fetch address, stable while if_req.
- if_rdata  out  DATA_W  fetched instruction, valid with if_valid.
- if_valid  out  1  one-cycle fetch completion pulse.
- if_stall  out  1  if_req && !if_valid.
- d_req  in  1  data request, level, held until d_valid.
- d_we  in  1  1 = store, 0 = load; stable while d_req.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data, valid with d_valid.
- d_valid  out  1  one-cycle data completion pulse (loads and stores).
- d_stall  out  1  d_req && !d_valid.
- mem_req  out  1  backing-memory request, registered.
- mem_we  out  1  backing-memory write enable, registered.
- mem_addr  out  ADDR_W  registered address.
- mem_wdata  out  DATA_W  registered write data.
- mem_rdata  in  DATA_W  read data, sampled when mem_ready.
- mem_ready  in  1  memory completion; may be high in the first mem_req cycle.

## Operation
- FSM states are IDLE, BUSY_I and BUSY_D.
- IDLE with any request pending:
  - Select the winner and register mem_req=1, mem_addr, mem_we and mem_wdata from the winner.
  - Go to BUSY_I or BUSY_D.
  - For a fetch, mem_we=0.
- Priority: d_req beats if_req, because MEM holds the older instruction.
- BUSY_x, mem_ready=0: hold all mem_* outputs stable.
- BUSY_x, mem_ready=1:
  - Register mem_rdata into x_rdata and pulse x_valid for one cycle.
  - Deassert mem_req and return to IDLE.
- Stores: d_rdata is left unchanged and d_valid still pulses.
- Requesters must hold req and operands until their valid. If a requester drops req while its access is in flight, the transaction still completes and valid still pulses; the requester discards it (e.g. fetch on branch flush).
- IDLE always lasts at least one cycle between transactions. A request whose valid pulses in cycle N is not re-arbitrated before cycle N+1.
- Reset values: state IDLE; mem_req, mem_we, if_valid and d_valid are 0; mem_addr, mem_wdata, if_rdata and d_rdata are 0. Starve counter is 0.
- Reset mid-transaction: mem_req drops immediately (asynchronous) and the access is abandoned. No valid pulse is issued for it.

## Timing
- Request sampled at edge 0 → mem_req high after edge 0. With mem_ready in that same cycle → x_valid high after edge 1.
- Minimum request-to-valid latency is 2 cycles; each memory wait cycle adds 1.
- Back-to-back throughput is one access per 3 cycles at zero wait.
- Both requests in IDLE: data is served first. The fetch starts at the earliest in the IDLE cycle after d_valid.
- if_stall and d_stall are combinational from req and valid.

## Configuration
- MEM_ARB_FAIR_EN defined:
  - A counter of consecutive data grants is maintained; it counts only while if_req was pending at the data grant.
  - When the counter reaches STARVE_LIMIT and both requests are pending in IDLE, the fetch wins and the counter clears.
  - Any fetch grant clears the counter.
- Not defined: strict data priority, no counter, and STARVE_LIMIT is unused.

## Structure
- Shared package mem_arb_pkg holds:
  - the state enum (IDLE, BUSY_I, BUSY_D);
  - an owner enum (OWN_I, OWN_D);
  - default ADDR_W and DATA_W constants.
- Single module; no sub-module. The starve counter is a few lines inside the `ifdef MEM_ARB_FAIR_EN block.

## Test plan
- Fetch alone, addr 0x10, mem_ready on the first cycle → mem_req one cycle, if_valid 2 cycles after request, if_rdata = mem_rdata.
- Load and fetch asserted in the same cycle (d_addr 0x100, if_addr 0x20) → mem_addr 0x100 first, d_valid, one IDLE cycle, then mem_addr 0x20, if_valid; if_stall high throughout until then.
- Store d_addr 0x40, d_wdata 0xDEADBEEF, memory with 3 wait cycles → mem_we=1 and stable mem_addr/mem_wdata for 4 cycles, d_valid pulses once, d_rdata unchanged.
- Reset asserted in BUSY_D before mem_ready → mem_req 0 at once; no d_valid after release; the next request is served normally.
- With MEM_ARB_FAIR_EN and STARVE_LIMIT=4: continuous d_req plus if_req → 4 data grants, then 1 fetch grant, repeating. Without the macro, the fetch never wins while d_req stays high.
- if_req dropped while in BUSY_I → transaction completes, if_valid pulses once, no new mem_req is issued.
